// File: rtl/jh_absorb_ctrl.sv
// JH absorb controller: packs 64-bit words into 512-bit blocks, chains them through F8 and
// returns H[511:0]. Define JH_PAD_EN to generate the trailing pad block internally.
module jh_absorb_ctrl #(
  parameter int unsigned F8_LAT = 44
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1023:0] iv,
  input  logic          msg_valid,
  output logic          msg_ready,
  input  logic [63:0]   msg_data,
  input  logic          msg_last,
  input  logic [3:0]    msg_bytes,
  output logic [1023:0] f8_in,
  input  logic [1023:0] f8_out,
  output logic          dig_valid,
  input  logic          dig_ready,
  output logic [511:0]  dig_data,
  output logic          busy
);

  localparam int unsigned CntW = $clog2(F8_LAT + 1);

  typedef enum logic [2:0] {StIdle, StCollect, StIssue, StWait, StUpdate, StDone} state_e;

  state_e          r_state, w_state_d;
  logic [1023:0]   r_h;
  logic [511:0]    r_m;
  logic [511:0]    w_m_new;
  logic [2:0]      r_widx, w_idx;
  logic [CntW-1:0] r_wcnt;
  logic            r_final;
  logic            r_dig_valid;
  logic [1023:0]   r_f8_in;
  logic [63:0]     w_word;
  logic            w_pad_next;
  logic            w_pad_pending;
  logic            w_accept;

`ifdef JH_PAD_EN
  logic [63:0]     r_len;
  logic            r_pad_pending;
  logic            r_pad80;
  logic [3:0]      w_bytes;
  assign w_pad_pending = r_pad_pending;
`else
  logic            w_unused_bytes;
  assign w_unused_bytes = ^msg_bytes;
  assign w_pad_pending  = 1'b0;
`endif

  assign msg_ready = rst_n && ((r_state == StIdle) || (r_state == StCollect));
  assign w_accept  = msg_valid && msg_ready;
  assign w_idx     = (r_state == StIdle) ? 3'd0 : r_widx;
  assign busy      = (r_state != StIdle);
  assign f8_in     = r_f8_in;
  assign dig_valid = r_dig_valid;
  assign dig_data  = r_h[511:0];

  // Word formatting; with padding the final word is truncated and tagged with 0x80.
  always_comb begin
    w_word     = msg_data;
    w_pad_next = 1'b0;
`ifdef JH_PAD_EN
    w_bytes = ((msg_bytes == 4'd0) || (msg_bytes > 4'd8)) ? 4'd8 : msg_bytes;
    if (msg_last) begin
      for (int k = 0; k < 8; k++) begin
        if (k == int'(w_bytes))     w_word[63-8*k -: 8] = 8'h80;
        else if (k > int'(w_bytes)) w_word[63-8*k -: 8] = 8'h00;
      end
      w_pad_next = (w_bytes == 4'd8);
    end
`endif
    w_m_new = (r_state == StIdle) ? '0 : r_m;
    for (int i = 0; i < 8; i++) begin
      if (i == int'(w_idx)) w_m_new[(7-i)*64 +: 64] = w_word;
      if (w_pad_next && (i == int'(w_idx) + 1)) w_m_new[(7-i)*64+56 +: 8] = 8'h80;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (w_accept) w_state_d = msg_last ? StIssue : StCollect;
      StCollect: if (w_accept && (msg_last || (w_idx == 3'd7))) w_state_d = StIssue;
      StIssue:   w_state_d = StWait;
      StWait:    if (r_wcnt == CntW'(F8_LAT - 1)) w_state_d = StUpdate;
      StUpdate: begin
        if (w_pad_pending) w_state_d = StIssue;
        else if (r_final)  w_state_d = StDone;
        else               w_state_d = StCollect;
      end
      StDone:    if (dig_ready) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h         <= '0;
      r_m         <= '0;
      r_widx      <= '0;
      r_wcnt      <= '0;
      r_final     <= 1'b0;
      r_dig_valid <= 1'b0;
      r_f8_in     <= '0;
`ifdef JH_PAD_EN
      r_len         <= '0;
      r_pad_pending <= 1'b0;
      r_pad80       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle, StCollect: begin
          if (w_accept) begin
            if (r_state == StIdle) r_h <= iv;
            r_m     <= w_m_new;
            r_widx  <= w_idx + 3'd1;
            r_final <= msg_last;
`ifdef JH_PAD_EN
            r_len <= ((r_state == StIdle) ? 64'd0 : r_len) +
                     (msg_last ? {57'd0, w_bytes, 3'd0} : 64'd64);
            if (msg_last) begin
              r_pad_pending <= 1'b1;
              r_pad80       <= w_pad_next && (w_idx == 3'd7);
            end
`endif
          end
        end
        StIssue: begin
          r_f8_in <= r_h ^ {r_m, 512'b0};
          r_wcnt  <= '0;
        end
        StWait: r_wcnt <= r_wcnt + CntW'(1);
        StUpdate: begin
          r_h    <= f8_out ^ {512'b0, r_m};
          r_widx <= '0;
          if (w_pad_pending) begin
`ifdef JH_PAD_EN
            // Length block: optional leading 0x80, 128-bit bit count with upper half zero.
            r_m           <= {(r_pad80 ? 8'h80 : 8'h00), 376'b0, 64'b0, r_len};
            r_pad_pending <= 1'b0;
`endif
          end else if (r_final) begin
            r_dig_valid <= 1'b1;
          end else begin
            r_m <= '0;
          end
        end
        StDone: if (dig_ready) r_dig_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
